// File: rtl/decode_multi.sv
// Multi-slot RV32I decode stage: takes the longest in-order prefix of fetched
// instructions that the free list can rename, and holds it as one registered group.
module decode_multi #(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned PRF_IDX_W = 6,
  parameter int unsigned CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [CNT_W-1:0]             ft_avail,
  input  logic [WIDTH*32-1:0]          ft_iq_rdata,
  input  logic [WIDTH*32-1:0]          ft_pcq_rdata,
  input  logic [WIDTH-1:0]             ft_bpq_rdata,
  output logic [CNT_W-1:0]             id_ft_deq_cnt,
  input  logic [CNT_W-1:0]             free_cnt,
  input  logic [WIDTH*PRF_IDX_W-1:0]   free_prd,
  output logic [CNT_W-1:0]             id_free_deq_cnt,
  input  logic                         disp_ready,
  output logic [WIDTH-1:0]             id_valid,
  output logic [WIDTH*32-1:0]          id_inst,
  output logic [WIDTH*32-1:0]          id_pc,
  output logic [WIDTH*5-1:0]           id_rs1,
  output logic [WIDTH*5-1:0]           id_rs2,
  output logic [WIDTH*5-1:0]           id_rd,
  output logic [WIDTH-1:0]             id_rd_we,
  output logic [WIDTH-1:0]             id_use_rs2,
  output logic [WIDTH-1:0]             id_is_load,
  output logic [WIDTH-1:0]             id_is_store,
  output logic [WIDTH-1:0]             id_br_pred,
  output logic [WIDTH-1:0]             id_illegal,
  output logic [WIDTH*PRF_IDX_W-1:0]   id_prd
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      inst;
    logic [XLEN-1:0]      pc;
    logic [REG_W-1:0]     rs1;
    logic [REG_W-1:0]     rs2;
    logic [REG_W-1:0]     rd;
    logic                 rd_we;
    logic                 use_rs2;
    logic                 is_load;
    logic                 is_store;
    logic                 br_pred;
    logic                 illegal;
    logic [PRF_IDX_W-1:0] prd;
  } slot_t;

  slot_t       slot_q [WIDTH];
  slot_t       slot_d [WIDTH];
  slot_t       cand_c [WIDTH];
  int unsigned avail_c;
  int unsigned free_c;
  int unsigned take_k;
  int unsigned take_nwr;
  logic        stop_c;
  logic        grp_valid_c;
  logic        open_c;
  logic        take_c;

  // Pure field/flag decode of one instruction word; valid and prd are filled later.
  function automatic slot_t decode_slot(input logic [XLEN-1:0] inst,
                                        input logic [XLEN-1:0] pc,
                                        input logic            bp);
    slot_t s;
    logic  rd_nz;
    s         = '0;
    s.inst    = inst;
    s.pc      = pc;
    s.rs1     = inst[19:15];
    s.rs2     = inst[24:20];
    s.rd      = inst[11:7];
    s.br_pred = bp;
    rd_nz     = (inst[11:7] != '0);
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OPIMM: s.rd_we = rd_nz;
      OPC_LOAD: begin
        s.rd_we   = rd_nz;
        s.is_load = 1'b1;
      end
      OPC_OP: begin
        s.rd_we   = rd_nz;
        s.use_rs2 = 1'b1;
      end
      OPC_BRANCH: s.use_rs2 = 1'b1;
      OPC_STORE: begin
        s.use_rs2  = 1'b1;
        s.is_store = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: s.rd_we = 1'b0;
      default: s.illegal = 1'b1;
    endcase
    return s;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cand_c[i] = decode_slot(ft_iq_rdata[i*XLEN +: XLEN],
                              ft_pcq_rdata[i*XLEN +: XLEN],
                              ft_bpq_rdata[i]);
    end
  end

  // Longest prefix whose rd-writers fit in the free list; writers take free_prd in order.
  always_comb begin
    avail_c  = (32'(ft_avail) > WIDTH) ? WIDTH : 32'(ft_avail);
    free_c   = (32'(free_cnt) > WIDTH) ? WIDTH : 32'(free_cnt);
    take_k   = 0;
    take_nwr = 0;
    stop_c   = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      slot_d[i] = '0;
      if (!stop_c && (i < avail_c) &&
          ((take_nwr + 32'(cand_c[i].rd_we)) <= free_c)) begin
        slot_d[i]       = cand_c[i];
        slot_d[i].valid = 1'b1;
        if (cand_c[i].rd_we) begin
          slot_d[i].prd = free_prd[take_nwr*PRF_IDX_W +: PRF_IDX_W];
          take_nwr      = take_nwr + 1;
        end
        take_k = i + 1;
      end else begin
        stop_c = 1'b1;
      end
    end
  end

  always_comb begin
    grp_valid_c = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      grp_valid_c = grp_valid_c | slot_q[i].valid;
    end
    open_c = ~grp_valid_c | disp_ready;
    take_c = rst & ~flush & open_c;
  end

  assign id_ft_deq_cnt   = take_c ? CNT_W'(take_k)   : '0;
  assign id_free_deq_cnt = take_c ? CNT_W'(take_nwr) : '0;

  // Output group register: flush empties it, an open slot reloads it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < WIDTH; i++) slot_q[i] <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < WIDTH; i++) slot_q[i] <= '0;
    end else if (take_c) begin
      for (int unsigned i = 0; i < WIDTH; i++) slot_q[i] <= slot_d[i];
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_out
    assign id_valid[g]                         = slot_q[g].valid;
    assign id_inst[g*XLEN +: XLEN]             = slot_q[g].inst;
    assign id_pc[g*XLEN +: XLEN]               = slot_q[g].pc;
    assign id_rs1[g*REG_W +: REG_W]            = slot_q[g].rs1;
    assign id_rs2[g*REG_W +: REG_W]            = slot_q[g].rs2;
    assign id_rd[g*REG_W +: REG_W]             = slot_q[g].rd;
    assign id_rd_we[g]                         = slot_q[g].rd_we;
    assign id_use_rs2[g]                       = slot_q[g].use_rs2;
    assign id_is_load[g]                       = slot_q[g].is_load;
    assign id_is_store[g]                      = slot_q[g].is_store;
    assign id_br_pred[g]                       = slot_q[g].br_pred;
    assign id_illegal[g]                       = slot_q[g].illegal;
    assign id_prd[g*PRF_IDX_W +: PRF_IDX_W]    = slot_q[g].prd;
  end

endmodule

// File: tb/tb_decode_multi.sv
// Bench for decode_multi (WIDTH=2): directed vectors, a prefix/rename model of the
// decode stage checked every cycle, and literal expectations for key scenarios.
module tb_decode_multi;
  localparam int W = 2;
  localparam int P = 6;
  localparam int C = 2;

  localparam logic [31:0] ADDI1 = 32'h00500093;
  localparam logic [31:0] ADD2  = 32'h00108133;
  localparam logic [31:0] ADD3  = 32'h002081B3;
  localparam logic [31:0] ADD4  = 32'h00208233;
  localparam logic [31:0] ADD0  = 32'h00208033;
  localparam logic [31:0] SW    = 32'h0020A023;
  localparam logic [31:0] LW5   = 32'h0000A283;
  localparam logic [31:0] BEQ   = 32'h00208063;
  localparam logic [31:0] LUI7  = 32'h123453B7;
  localparam logic [31:0] JAL1  = 32'h000000EF;
  localparam logic [31:0] FENCE = 32'h0000000F;
  localparam logic [31:0] ILL   = 32'hFFFFFFFF;
  localparam logic [31:0] CUST  = 32'h0000000B;

  logic clk = 1'b0;
  logic rst, flush, disp_ready;
  logic [C-1:0] ft_avail, free_cnt;
  logic [31:0] ins [W];
  logic [31:0] pcs [W];
  logic [P-1:0] fp [W];
  logic [W-1:0] bp;
  logic [31:0] pcbase = 32'h1000;

  logic [W*32-1:0] ft_iq_rdata, ft_pcq_rdata;
  logic [W*P-1:0]  free_prd;
  logic [C-1:0]    id_ft_deq_cnt, id_free_deq_cnt;
  logic [W-1:0]    id_valid, id_rd_we, id_use_rs2, id_is_load, id_is_store, id_br_pred, id_illegal;
  logic [W*32-1:0] id_inst, id_pc;
  logic [W*5-1:0]  id_rs1, id_rs2, id_rd;
  logic [W*P-1:0]  id_prd;

  assign ft_iq_rdata  = {ins[1], ins[0]};
  assign ft_pcq_rdata = {pcs[1], pcs[0]};
  assign free_prd     = {fp[1], fp[0]};

  decode_multi #(.WIDTH(W), .PRF_IDX_W(P), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ft_avail(ft_avail), .ft_iq_rdata(ft_iq_rdata), .ft_pcq_rdata(ft_pcq_rdata),
    .ft_bpq_rdata(bp), .id_ft_deq_cnt(id_ft_deq_cnt),
    .free_cnt(free_cnt), .free_prd(free_prd), .id_free_deq_cnt(id_free_deq_cnt),
    .disp_ready(disp_ready), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_use_rs2(id_use_rs2), .id_is_load(id_is_load), .id_is_store(id_is_store),
    .id_br_pred(id_br_pred), .id_illegal(id_illegal), .id_prd(id_prd)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: ISA-level classification plus the in-order rename-fit rule.
  function automatic bit legal(input logic [31:0] w);
    return w[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
  endfunction

  function automatic bit writes(input logic [31:0] w);
    return (w[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33}) && (w[11:7] != 5'd0);
  endfunction

  function automatic void plan(output int k, output int nw);
    int a, f;
    a  = (int'(ft_avail) > W) ? W : int'(ft_avail);
    f  = (int'(free_cnt) > W) ? W : int'(free_cnt);
    k  = 0;
    nw = 0;
    for (int i = 0; i < a; i++) begin
      if (nw + int'(writes(ins[i])) > f) break;
      nw = nw + int'(writes(ins[i]));
      k  = i + 1;
    end
  endfunction

  bit          m_valid [W] = '{0, 0};
  logic [31:0] m_inst  [W];
  logic [31:0] m_pc    [W];
  logic        m_bp    [W];
  logic [P-1:0] m_prd  [W];

  always @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      for (int i = 0; i < W; i++) m_valid[i] = 0;
    end else if (!(m_valid[0] || m_valid[1]) || disp_ready) begin
      int k, nw, n;
      plan(k, nw);
      n = 0;
      for (int i = 0; i < W; i++) begin
        m_valid[i] = (i < k);
        m_inst[i]  = ins[i];
        m_pc[i]    = pcs[i];
        m_bp[i]    = bp[i];
        m_prd[i]   = '0;
        if (i < k && writes(ins[i])) begin
          m_prd[i] = fp[n];
          n++;
        end
      end
    end
  end

  always @(negedge clk) begin
    int k, nw;
    bit take;
    logic [31:0] w;
    plan(k, nw);
    take = rst && !flush && (!(m_valid[0] || m_valid[1]) || disp_ready);
    chk("ft_deq", 64'(id_ft_deq_cnt), take ? 64'(k) : 64'd0);
    chk("free_deq", 64'(id_free_deq_cnt), take ? 64'(nw) : 64'd0);
    chk("valid", 64'(id_valid), {62'd0, m_valid[1], m_valid[0]});
    for (int i = 0; i < W; i++) begin
      if (m_valid[i]) begin
        w = m_inst[i];
        chk("inst", 64'(id_inst[i*32 +: 32]), 64'(w));
        chk("pc", 64'(id_pc[i*32 +: 32]), 64'(m_pc[i]));
        chk("regs", 64'({id_rs1[i*5 +: 5], id_rs2[i*5 +: 5], id_rd[i*5 +: 5]}),
            64'({w[19:15], w[24:20], w[11:7]}));
        chk("flags", 64'({id_rd_we[i], id_use_rs2[i], id_is_load[i], id_is_store[i], id_br_pred[i], id_illegal[i]}),
            64'({writes(w), w[6:0] inside {7'h33, 7'h63, 7'h23}, w[6:0] == 7'h03, w[6:0] == 7'h23,
                 m_bp[i], !legal(w)}));
        chk("prd", 64'(id_prd[i*P +: P]), writes(w) ? 64'(m_prd[i]) : 64'd0);
      end
    end
  end

  task automatic setv(input int av, input logic [31:0] a, input logic [31:0] b, input int fr,
                      input int p0, input int p1, input logic d, input logic fl);
    ft_avail   = C'(av);
    ins[0]     = a;
    ins[1]     = b;
    free_cnt   = C'(fr);
    fp[0]      = P'(p0);
    fp[1]      = P'(p1);
    disp_ready = d;
    flush      = fl;
    pcs[0]     = pcbase;
    pcs[1]     = pcbase + 32'd4;
    bp         = 2'(pcbase[4:3]);
    pcbase     = pcbase + 32'd8;
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  int          t_av [12] = '{2, 2, 1, 3, 2, 0, 2, 2, 2, 1, 2, 2};
  logic [31:0] t_i0 [12] = '{LUI7, LW5, JAL1, FENCE, ADD0, ADD3, CUST, ADDI1, SW, LW5, ADD3, BEQ};
  logic [31:0] t_i1 [12] = '{JAL1, ADD4, ADD2, SW, LW5, ADD4, ADD3, ADD2, BEQ, ADD2, ADD4, LUI7};
  int          t_fr [12] = '{2, 1, 3, 0, 1, 2, 1, 2, 0, 1, 0, 3};
  bit          t_d  [12] = '{1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
  bit          t_fl [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    rst = 1'b0;
    setv(2, ADDI1, ADD2, 2, 10, 11, 1'b1, 1'b0);
    @(negedge clk);
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_ft_deq", 64'(id_ft_deq_cnt), 64'd0);
    chk("rst_free_deq", 64'(id_free_deq_cnt), 64'd0);
    chk("rst_inst", 64'(id_inst), 64'd0);
    chk("rst_prd", 64'(id_prd), 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("v1_deq", 64'({id_ft_deq_cnt, id_free_deq_cnt}), 64'({2'd2, 2'd2}));

    next();
    setv(2, ADD3, ADD4, 1, 20, 21, 1'b1, 1'b0);
    @(negedge clk);
    chk("v1_valid", 64'(id_valid), 64'b11);
    chk("v1_prd", 64'(id_prd), 64'({6'd11, 6'd10}));
    chk("v2_deq", 64'({id_ft_deq_cnt, id_free_deq_cnt}), 64'({2'd1, 2'd1}));

    next();
    setv(2, SW, ADD0, 0, 0, 0, 1'b1, 1'b0);
    @(negedge clk);
    chk("v2_valid", 64'(id_valid), 64'b01);
    chk("v2_prd", 64'(id_prd[5:0]), 64'd20);
    chk("v3_deq", 64'({id_ft_deq_cnt, id_free_deq_cnt}), 64'({2'd2, 2'd0}));

    next();
    setv(2, LW5, BEQ, 2, 40, 41, 1'b0, 1'b0);
    @(negedge clk);
    chk("v3_valid", 64'(id_valid), 64'b11);
    chk("v3_rd_we", 64'(id_rd_we), 64'b00);
    chk("v3_store", 64'(id_is_store), 64'b01);
    chk("hold_deq", 64'({id_ft_deq_cnt, id_free_deq_cnt}), 64'd0);
    repeat (2) begin
      next();
      @(negedge clk);
      chk("hold_deq", 64'({id_ft_deq_cnt, id_free_deq_cnt}), 64'd0);
      chk("hold_inst", 64'(id_inst), {ADD0, SW});
    end
    next();
    disp_ready = 1'b1;
    @(negedge clk);
    chk("v4_deq", 64'({id_ft_deq_cnt, id_free_deq_cnt}), 64'({2'd2, 2'd1}));

    next();
    setv(2, ADD3, ADD4, 2, 1, 2, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush_valid_before", 64'(id_valid), 64'b11);
    chk("flush_deq", 64'({id_ft_deq_cnt, id_free_deq_cnt}), 64'd0);

    next();
    setv(3, ILL, LW5, 3, 32, 33, 1'b1, 1'b0);
    @(negedge clk);
    chk("flush_valid_after", 64'(id_valid), 64'd0);
    chk("v6_deq", 64'({id_ft_deq_cnt, id_free_deq_cnt}), 64'({2'd2, 2'd1}));

    next();
    setv(0, ADD3, ADD4, 2, 1, 2, 1'b1, 1'b0);
    @(negedge clk);
    chk("v6_valid", 64'(id_valid), 64'b11);
    chk("v6_illegal", 64'(id_illegal), 64'b01);
    chk("v6_prd", 64'(id_prd), 64'({6'd32, 6'd0}));

    next();
    setv(2, LW5, ADD3, 0, 5, 6, 1'b1, 1'b0);
    @(negedge clk);
    chk("k0_clear", 64'(id_valid), 64'd0);
    chk("k0_deq", 64'({id_ft_deq_cnt, id_free_deq_cnt}), 64'd0);

    for (int r = 0; r < 12; r++) begin
      next();
      setv(t_av[r], t_i0[r], t_i1[r], t_fr[r], 50 + r, 60 + r, t_d[r], t_fl[r]);
    end

    next();
    setv(2, ADDI1, ADD2, 2, 7, 8, 1'b1, 1'b0);
    next();
    disp_ready = 1'b0;
    @(posedge clk);
    #1 chk("pre_rst_valid", 64'(id_valid), 64'b11);
    #2 rst = 1'b0;
    #1 chk("async_rst_valid", 64'(id_valid), 64'd0);
    chk("async_rst_deq", 64'({id_ft_deq_cnt, id_free_deq_cnt}), 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    disp_ready = 1'b1;
    repeat (3) next();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
